fp_align_arbiter: RTL and testbench
===================================

# fp_align_arbiter

Two-requester round-robin scheduler that shares one combinational FP operand-alignment unit (27-bit format: sign[26], signed exponent[25:18], fraction[17:0]) between two upstream producers, e.g. two FP add/sub front-ends. It accepts operand pairs over valid/ready handshakes and registers them into the aligner's inputs. It then captures the aligned pair into an output register with its own valid/ready handshake and requester ID. It also keeps per-requester grant counters.

## Interface
- EXP_W, 8, exponent field width
- FRAC_W, 18, fraction field width; word width W = 1+EXP_W+FRAC_W (27)
- CNT_W, 16, grant counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- r0_valid  in  1  requester 0 operand pair valid
- r0_ready  out  1  requester 0 pair accepted this cycle
- r0_in_1, r0_in_2  in  W  requester 0 operands
- r1_valid, r1_ready, r1_in_1, r1_in_2: same for requester 1
- aln_in_1, aln_in_2  out  W  registered operands driven to aligner
- aln_out_1, aln_out_2  in  W  aligner outputs, combinational from aln_in_*
- res_valid  out  1  aligned pair available
- res_ready  in  1  consumer takes result
- res_out_1, res_out_2  out  W  aligned pair
- res_id  out  1  requester that issued the result
- clr_cnt  in  1  synchronous clear of grant counters
- cnt_0, cnt_1  out  CNT_W  accepted-pair counts per requester

## Operation
- Two-stage pipeline. S1 holds s1_valid, s1_id, aln_in_1/2. S2 holds res_valid, res_id, res_out_1/2.
- Occupancy states: EMPTY, S1_ONLY, S2_ONLY, FULL. They are derived from s1_valid and res_valid.
- s2_load = s1_valid && (!res_valid || res_ready). On s2_load, S2 captures aln_out_1/2 and s1_id.
- s1_en = !s1_valid || s2_load. When s1_en and some request is valid, exactly one requester is granted. S1 captures its operands and ID.
- Arbitration uses a 1-bit pointer ptr, which names the preferred requester.
  - If only one requester is valid, that requester is granted.
  - If both are valid, ptr's requester is granted.
  - After any grant to k, ptr becomes !k.
  - With no grant, ptr holds.
- rk_ready = s1_en && grant==k. It is combinational from valids and res_ready. Ready never asserts for a non-valid requester.
- res_valid clears when res_ready && !s2_load. res_valid stays set on a simultaneous drain and load.
- S2 holds data stable while res_valid && !res_ready.
- The block never modifies operand bits. All alignment arithmetic is in the aligner.
  - Every res_out_1 and res_out_2 pair has equal exponent fields.
  - Every res_out_1 and res_out_2 pair has the same signs as the accepted inputs.
- Counters:
  - cnt_k increments on each r-k accept.
  - cnt_k saturates at all-ones.
  - clr_cnt takes priority over a same-cycle increment. Both counters then read 0 next cycle.

## Timing
- Reset values:
  - r0_ready and r1_ready read 0 during reset, because s1_valid is forced 0 but s1_en is then 1; ready is gated with !rst.
  - aln_in_1/2 = 0.
  - res_valid = 0, res_out_1/2 = 0, res_id = 0.
  - ptr = 0, so requester 0 is preferred.
  - cnt_0 = cnt_1 = 0.
- Reset mid-operation discards S1 and S2 contents immediately. In-flight pairs are lost and not replayed.
- Latency and throughput:
  - A pair is accepted at edge N.
  - aln_in_* is valid from edge N.
  - res_valid is 1 after edge N+1, i.e. 2-cycle accept-to-result.
  - Throughput is 1 pair/cycle when res_ready is held 1.
- Backpressure:
  - With res_ready=0 and the pipeline FULL, both ready outputs are 0.
  - On the first res_ready=1 cycle, S2 drains, S1 advances and a new grant occurs in that same cycle.
- Simultaneous requests alternate grants every accept. Neither requester waits more than one accept while the other is valid.

## Test plan
- Reset, then r0 alone with r0_in_1=27'h0E0000 (exp 3, frac 20000h) and r0_in_2=27'h060000 (exp 1), res_ready=1:
  - r0_ready=1 in cycle 0.
  - res_valid=1 two edges later with res_out_1=27'h0E0000, res_out_2=27'h0C8000, res_id=0.
  - cnt_0=1.
- Both requesters valid continuously for 6 cycles, res_ready=1:
  - Grants go r0,r1,r0,r1,r0,r1.
  - res_id sequence is 0,1,0,1,0,1 with 1 result/cycle.
  - cnt_0=cnt_1=3.
- Both requesters valid, res_ready=0 for 5 cycles:
  - Exactly 2 accepts, then both readies are 0.
  - res_out stays stable.
  - res_ready=1 produces results in order with no loss or duplication.
- Assert rst while the pipeline is FULL:
  - res_valid=0 and all outputs are at reset values immediately, without waiting for an edge.
  - After release, the first grant goes to r0 when both requesters are valid.
- Preload cnt_0 to all-ones via 65535 accepts (or force), then:
  - One more r0 accept leaves cnt_0=FFFFh.
  - clr_cnt coincident with an accept gives cnt_0=0.
- Random valid/ready on all ports for 10k cycles with the aligner connected, plus a scoreboard:
  - Every accepted pair appears once, in accept order, with the correct res_id.
  - Exponent fields of res_out_1 and res_out_2 are equal.

Source files
------------

// File: rtl/fp_align_arbiter.sv
// Round-robin sharing of one combinational FP operand aligner between two requesters.
// The operand register feeds the aligner and a result register captures its output.
module fp_align_arbiter #(
    parameter  int EXP_W  = 8,
    parameter  int FRAC_W = 18,
    parameter  int CNT_W  = 16,
    localparam int W      = 1 + EXP_W + FRAC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [W-1:0]     r0_in_1,
    input  logic [W-1:0]     r0_in_2,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [W-1:0]     r1_in_1,
    input  logic [W-1:0]     r1_in_2,
    output logic [W-1:0]     aln_in_1,
    output logic [W-1:0]     aln_in_2,
    input  logic [W-1:0]     aln_out_1,
    input  logic [W-1:0]     aln_out_2,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_out_1,
    output logic [W-1:0]     res_out_2,
    output logic             res_id,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_0,
    output logic [CNT_W-1:0] cnt_1
);

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        S2_ONLY = 2'b01,
        S1_ONLY = 2'b10,
        FULL    = 2'b11
    } occ_t;

    occ_t occ;
    logic s1_valid;
    logic s1_id;
    logic ptr;
    logic grant_id;
    logic s2_load;
    logic s1_en;
    logic do_grant;

    always_comb begin
        occ = occ_t'({s1_valid, res_valid});
    end

    assign s2_load = (occ == S1_ONLY) || ((occ == FULL) && res_ready);
    assign s1_en   = (occ == EMPTY) || (occ == S2_ONLY) || s2_load;

    // A lone requester always wins; on contention ptr names the winner.
    always_comb begin
        grant_id = 1'b0;
        if (r0_valid && r1_valid) begin
            grant_id = ptr;
        end else if (r1_valid) begin
            grant_id = 1'b1;
        end
    end

    // During reset s1_en is 1 because s1_valid is cleared, so ready must be masked.
    assign do_grant = s1_en && (r0_valid || r1_valid) && !rst;
    assign r0_ready = do_grant && !grant_id;
    assign r1_ready = do_grant && grant_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= 1'b0;
            s1_valid  <= 1'b0;
            s1_id     <= 1'b0;
            aln_in_1  <= '0;
            aln_in_2  <= '0;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_out_1 <= '0;
            res_out_2 <= '0;
        end else begin
            if (do_grant) begin
                ptr      <= !grant_id;
                s1_id    <= grant_id;
                aln_in_1 <= grant_id ? r1_in_1 : r0_in_1;
                aln_in_2 <= grant_id ? r1_in_2 : r0_in_2;
            end
            if (s1_en) begin
                s1_valid <= do_grant;
            end
            // A simultaneous drain and load keeps res_valid set with the new pair.
            if (s2_load) begin
                res_valid <= 1'b1;
                res_id    <= s1_id;
                res_out_1 <= aln_out_1;
                res_out_2 <= aln_out_2;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    // Saturating grant counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_0 <= '0;
            cnt_1 <= '0;
        end else if (clr_cnt) begin
            cnt_0 <= '0;
            cnt_1 <= '0;
        end else begin
            if (r0_ready && (cnt_0 != '1)) begin
                cnt_0 <= cnt_0 + 1'b1;
            end
            if (r1_ready && (cnt_1 != '1)) begin
                cnt_1 <= cnt_1 + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp_align_arbiter.sv
// Scoreboard bench for fp_align_arbiter with a behavioural aligner and reference model.
// Accepts push expected aligned pairs; a separate monitor pops them as results leave.
module tb_fp_align_arbiter;

    localparam int W = 27;

    logic          clk = 1'b0;
    logic          rst;
    logic          r0_valid, r1_valid, r0_ready, r1_ready;
    logic [W-1:0]  r0_in_1, r0_in_2, r1_in_1, r1_in_2;
    logic [W-1:0]  aln_in_1, aln_in_2, aln_out_1, aln_out_2;
    logic          res_valid, res_ready, res_id, clr_cnt;
    logic [W-1:0]  res_out_1, res_out_2;
    logic [15:0]   cnt_0, cnt_1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct packed {
        logic         id;
        logic [W-1:0] o1;
        logic [W-1:0] o2;
        logic [31:0]  cyc;
    } exp_t;

    exp_t sb_q[$];

    fp_align_arbiter #(.EXP_W(8), .FRAC_W(18), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_in_1(r0_in_1), .r0_in_2(r0_in_2),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_in_1(r1_in_1), .r1_in_2(r1_in_2),
        .aln_in_1(aln_in_1), .aln_in_2(aln_in_2), .aln_out_1(aln_out_1), .aln_out_2(aln_out_2),
        .res_valid(res_valid), .res_ready(res_ready), .res_out_1(res_out_1), .res_out_2(res_out_2),
        .res_id(res_id), .clr_cnt(clr_cnt), .cnt_0(cnt_0), .cnt_1(cnt_1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference alignment: keep the larger-exponent operand, shift the other's fraction right.
    function automatic logic [2*W-1:0] align_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        int ea, eb, d;
        logic [17:0] f;
        ea = int'($signed(a[25:18]));
        eb = int'($signed(b[25:18]));
        if (ea >= eb) begin
            d = ea - eb;
            f = (d > 17) ? 18'd0 : (b[17:0] >> d);
            return {a, b[26], a[25:18], f};
        end
        d = eb - ea;
        f = (d > 17) ? 18'd0 : (a[17:0] >> d);
        return {a[26], b[25:18], f, b};
    endfunction

    always_comb {aln_out_1, aln_out_2} = align_ref(aln_in_1, aln_in_2);

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] w;
        w = W'($urandom());
        w[25:18] = 8'($urandom_range(0, 31)) - 8'd16;
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic v1, input logic rr, input logic cc);
        r0_valid  = v0;
        r1_valid  = v1;
        res_ready = rr;
        clr_cnt   = cc;
        r0_in_1   = rnd_word();
        r0_in_2   = rnd_word();
        r1_in_1   = rnd_word();
        r1_in_2   = rnd_word();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus-side tracker: arbitration rules, counter model and expected-result pushes.
    logic        pref;
    logic [15:0] m_cnt0, m_cnt1;

    always @(negedge clk) begin
        logic acc0, acc1, rules_ok;
        exp_t e;
        logic [2*W-1:0] al;
        if (rst) begin
            sb_q.delete();
            pref   = 1'b0;
            m_cnt0 = '0;
            m_cnt1 = '0;
        end else begin
            checkOutput("cnt_0", 64'(cnt_0), 64'(m_cnt0));
            checkOutput("cnt_1", 64'(cnt_1), 64'(m_cnt1));
            acc0 = r0_valid && r0_ready;
            acc1 = r1_valid && r1_ready;
            rules_ok = !(r0_ready && !r0_valid) && !(r1_ready && !r1_valid) && !(r0_ready && r1_ready);
            checkOutput("ready_rules", 64'(rules_ok), 64'd1);
            if (acc0 || acc1) begin
                if (r0_valid && r1_valid) begin
                    checkOutput("rr_winner", 64'(acc1), 64'(pref));
                end
                pref = !acc1;
                al = acc1 ? align_ref(r1_in_1, r1_in_2) : align_ref(r0_in_1, r0_in_2);
                e.id  = acc1;
                e.o1  = al[2*W-1:W];
                e.o2  = al[W-1:0];
                e.cyc = 32'(cyc);
                sb_q.push_back(e);
            end
            if (clr_cnt) begin
                m_cnt0 = '0;
                m_cnt1 = '0;
            end else begin
                if (acc0 && m_cnt0 != 16'hFFFF) m_cnt0 = m_cnt0 + 16'd1;
                if (acc1 && m_cnt1 != 16'hFFFF) m_cnt1 = m_cnt1 + 16'd1;
            end
        end
    end

    // Result monitor: pops the oldest expected pair whenever a result is taken.
    logic         prev_hold;
    logic [2*W:0] prev_res;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                checkOutput("hold_valid", 64'(res_valid), 64'd1);
                checkOutput("hold_data", 64'({res_id, res_out_1, res_out_2}), 64'(prev_res));
            end
            if (res_valid && res_ready) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("res_out_1", 64'(res_out_1), 64'(e.o1));
                    checkOutput("res_out_2", 64'(res_out_2), 64'(e.o2));
                    checkOutput("res_id", 64'(res_id), 64'(e.id));
                    checkOutput("latency_ge2", 64'(32'(cyc) >= e.cyc + 32'd2), 64'd1);
                end
                checkOutput("exp_equal", 64'(res_out_1[25:18] == res_out_2[25:18]), 64'd1);
            end
            prev_hold = res_valid && !res_ready;
            prev_res  = {res_id, res_out_1, res_out_2};
        end
    end

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int acc;
        logic [2*W-1:0] snap;

        // Reset values with r0 already requesting.
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        r0_in_1 = 27'h0E0000;
        r0_in_2 = 27'h060000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_r0_ready", 64'(r0_ready), 64'd0);
        checkOutput("rst_aln_in_1", 64'(aln_in_1), 64'd0);
        checkOutput("rst_res_valid", 64'(res_valid), 64'd0);
        checkOutput("rst_res_out_1", 64'(res_out_1), 64'd0);
        checkOutput("rst_res_id", 64'(res_id), 64'd0);
        checkOutput("rst_cnt_0", 64'(cnt_0), 64'd0);
        tick();
        rst = 1'b0;

        // Single r0 pair: accepted in cycle 0, result two edges later.
        @(negedge clk);
        checkOutput("t1_r0_ready", 64'(r0_ready), 64'd1);
        tick();
        r0_valid = 1'b0;
        @(negedge clk);
        checkOutput("t1_aln_in_1", 64'(aln_in_1), 64'h0E0000);
        checkOutput("t1_res_valid_early", 64'(res_valid), 64'd0);
        tick();
        @(negedge clk);
        checkOutput("t1_res_valid", 64'(res_valid), 64'd1);
        checkOutput("t1_res_out_1", 64'(res_out_1), 64'h0E0000);
        checkOutput("t1_res_out_2", 64'(res_out_2), 64'h0C8000);
        checkOutput("t1_res_id", 64'(res_id), 64'd0);
        checkOutput("t1_cnt_0", 64'(cnt_0), 64'd1);
        tick();

        // Continuous contention with free output: strict alternation, 1 result/cycle.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i < 6) begin
                checkOutput("t2_r0_ready", 64'(r0_ready), 64'(i % 2 == 0));
                checkOutput("t2_r1_ready", 64'(r1_ready), 64'(i % 2 == 1));
            end
            if (i >= 2) begin
                checkOutput("t2_res_valid", 64'(res_valid), 64'd1);
                checkOutput("t2_res_id", 64'(res_id), 64'((i - 2) % 2));
            end
            tick();
            applyStimulus(i != 5 && i < 6, i != 5 && i < 6, 1'b1, 1'b0);
        end
        @(negedge clk);
        checkOutput("t2_cnt_0", 64'(cnt_0), 64'd3);
        checkOutput("t2_cnt_1", 64'(cnt_1), 64'd3);
        tick();

        // Backpressure: two accepts fill the pipe, then everything stalls.
        acc = 0;
        snap = '0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            acc += int'(r0_ready) + int'(r1_ready);
            if (i == 2) snap = {res_out_1, res_out_2};
            if (i == 4) begin
                checkOutput("t3_stall_readies", 64'({r0_ready, r1_ready}), 64'd0);
                checkOutput("t3_res_stable", 64'({res_out_1, res_out_2}), 64'(snap));
            end
            tick();
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("t3_accepts", 64'(acc), 64'd2);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t3_grant_on_release", 64'(r0_ready || r1_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        end
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) tick();

        // Reset while FULL clears outputs asynchronously; r0 preferred afterwards.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkOutput("t4_res_valid", 64'(res_valid), 64'd0);
        checkOutput("t4_res_out", 64'({res_out_1, res_out_2}), 64'd0);
        checkOutput("t4_res_id", 64'(res_id), 64'd0);
        checkOutput("t4_aln_in", 64'({aln_in_1, aln_in_2}), 64'd0);
        checkOutput("t4_readies", 64'({r0_ready, r1_ready}), 64'd0);
        checkOutput("t4_cnts", 64'({cnt_0, cnt_1}), 64'd0);
        tick();
        rst = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        checkOutput("t4_first_grant", 64'({r0_ready, r1_ready}), 64'b10);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) tick();

        // Saturate cnt_0 and then clear it coincident with an accept.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 65536; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        @(negedge clk);
        checkOutput("t5_cnt_0_sat", 64'(cnt_0), 64'hFFFF);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("t5_clr_accept", 64'(r0_ready), 64'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t5_cnt_0_clr", 64'(cnt_0), 64'd0);
        repeat (3) tick();

        // Random traffic on every port; the scoreboard does the checking.
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0));
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) tick();
        @(negedge clk);
        checkOutput("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
